// File: rtl/pc_ir_unit_pkg.sv
// pc_ir_unit_pkg: shared CPU definitions used by the instruction-sequencing stage.
//   pc_sel_t   : PC select encoding driven by the control unit
//   BR_OFF_W   : width of the branch offset field carried in the instruction
//   br_offset(): extracts {ins[8:6], ins[2:0]} and sign-extends it to 16 bits
package pc_ir_unit_pkg;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BR   = 2'b10,
    PS_JMP  = 2'b11
  } pc_sel_t;

  localparam int BR_OFF_W = 6;

  // The offset field is split across the instruction word: the high half
  // sits in bits 8:6, the low half in bits 2:0.
  function automatic logic [15:0] br_offset(input logic [15:0] ins);
    logic [BR_OFF_W-1:0] off;
    off = {ins[8:6], ins[2:0]};
    return {{(16-BR_OFF_W){off[BR_OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter and instruction register feeding the control unit.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   ps_in[1:0]       PC select: hold / increment / branch / jump
//   il_in            instruction load strobe; captures mem_data_in into IR
//   mem_data_in[15:0] memory read data
//   a_in[15:0]       register-file A bus, jump target (low ADDR_W bits used)
//   pc_out           registered PC
//   ins_out[15:0]    registered IR
//   ir_valid_out     sticky: IR loaded at least once since reset
//   pc_wrap_out      one-cycle pulse after an increment/branch wrapped the PC
//   instr_cnt_out    IR load count      (PC_IR_STATS_EN, else 0)
//   taken_cnt_out    branch/jump count  (PC_IR_STATS_EN, else 0)
//
// Optional: define PC_IR_STATS_EN to build the two 32-bit event counters.
module pc_ir_unit
  import pc_ir_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ps_in,
  input  logic              il_in,
  input  logic [15:0]       mem_data_in,
  input  logic [15:0]       a_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       ins_out,
  output logic              ir_valid_out,
  output logic              pc_wrap_out,
  output logic [31:0]       instr_cnt_out,
  output logic [31:0]       taken_cnt_out
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_valid_q;
  logic              wrap_q, wrap_d;

  pc_sel_t     ps;
  logic [15:0] off;
  logic [17:0] br_sum;
  logic        unused_a_hi;

  assign ps  = pc_sel_t'(ps_in);
  // Offset always comes from the IR as it stands before this edge, so a
  // same-edge load never feeds the branch it coincides with.
  assign off = br_offset(ir_q);

  // Zero-extended PC plus sign-extended offset in 18 bits: any set bit at or
  // above ADDR_W means the true result left [0, 2^ADDR_W), in either direction.
  assign br_sum = {{(18-ADDR_W){1'b0}}, pc_q} + {{2{off[15]}}, off};

  // Only the low ADDR_W bits of the A bus form a jump target.
  assign unused_a_hi = ^(a_in >> ADDR_W);

  always_comb begin
    pc_d   = pc_q;
    wrap_d = 1'b0;
    unique case (ps)
      PS_HOLD: pc_d = pc_q;
      PS_INC: begin
        pc_d   = pc_q + ADDR_W'(1);
        wrap_d = &pc_q;
      end
      PS_BR: begin
        pc_d   = br_sum[ADDR_W-1:0];
        wrap_d = |br_sum[17:ADDR_W];
      end
      PS_JMP:  pc_d = a_in[ADDR_W-1:0];
      default: pc_d = pc_q;
    endcase
  end

  assign ir_d = il_in ? mem_data_in : ir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_q | il_in;
      wrap_q     <= wrap_d;
    end
  end

  assign pc_out       = pc_q;
  assign ins_out      = ir_q;
  assign ir_valid_out = ir_valid_q;
  assign pc_wrap_out  = wrap_q;

`ifdef PC_IR_STATS_EN
  logic [31:0] instr_cnt_q, taken_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (il_in)    instr_cnt_q <= instr_cnt_q + 32'd1;
      if (ps_in[1]) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign instr_cnt_out = instr_cnt_q;
  assign taken_cnt_out = taken_cnt_q;
`else
  assign instr_cnt_out = 32'h0;
  assign taken_cnt_out = 32'h0;
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
module tb_pc_ir_unit;

  localparam int         AW  = 8;
  localparam logic [7:0] RPC = 8'h10;
  localparam int         MOD = 1 << AW;

  logic        clk;
  logic        rst;
  logic [1:0]  ps_in;
  logic        il_in;
  logic [15:0] mem_data_in;
  logic [15:0] a_in;
  logic [7:0]  pc_out;
  logic [15:0] ins_out;
  logic        ir_valid_out;
  logic        pc_wrap_out;
  logic [31:0] instr_cnt_out;
  logic [31:0] taken_cnt_out;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  pc_ir_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .ps_in(ps_in), .il_in(il_in),
    .mem_data_in(mem_data_in), .a_in(a_in),
    .pc_out(pc_out), .ins_out(ins_out), .ir_valid_out(ir_valid_out),
    .pc_wrap_out(pc_wrap_out), .instr_cnt_out(instr_cnt_out),
    .taken_cnt_out(taken_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (integer arithmetic) ----------------
  int          m_pc;
  logic [15:0] m_ir;
  bit          m_valid;
  bit          m_wrap;
  longint      m_ic;
  longint      m_tc;

  function automatic int off6_of(input logic [15:0] ir);
    int v;
    v = int'(ir[8:6]) * 8 + int'(ir[2:0]);
    if (v >= 32) v = v - 64;
    return v;
  endfunction

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      m_pc = int'(RPC); m_ir = 16'h0; m_valid = 0; m_wrap = 0; m_ic = 0; m_tc = 0;
    end else begin
      nxt = m_pc;
      case (ps_in)
        2'd1: nxt = m_pc + 1;
        2'd2: nxt = m_pc + off6_of(m_ir);
        2'd3: nxt = int'(a_in) % MOD;
        default: nxt = m_pc;
      endcase
      m_wrap = (ps_in == 2'd1 || ps_in == 2'd2) && (nxt < 0 || nxt >= MOD);
      m_pc   = (nxt + 2 * MOD) % MOD;
      if (il_in) begin m_ir = mem_data_in; m_valid = 1; end
      if (il_in) m_ic = m_ic + 1;
      if (ps_in[1]) m_tc = m_tc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input longint c);
`ifdef PC_IR_STATS_EN
    return c[31:0];
`else
    return (c == c) ? 32'h0 : 32'h0;
`endif
  endfunction

  // Compare process: outputs settle at posedge, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",       32'(pc_out),       32'(m_pc));
      chk("ins",      32'(ins_out),      32'(m_ir));
      chk("ir_valid", 32'(ir_valid_out), 32'(m_valid));
      chk("wrap",     32'(pc_wrap_out),  32'(m_wrap));
      chk("icnt",     instr_cnt_out,     exp_cnt(m_ic));
      chk("tcnt",     taken_cnt_out,     exp_cnt(m_tc));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drv(input logic r, input logic [1:0] ps, input logic il,
                     input logic [15:0] mem, input logic [15:0] a);
    rst = r; ps_in = ps; il_in = il; mem_data_in = mem; a_in = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; ps_in = 2'd1; il_in = 0; mem_data_in = 16'h0; a_in = 16'h0;

    // reset held two cycles with increment requested: ignored
    drv(1, 2'd1, 0, 16'h0, 16'h0);
    chk_en = 1;
    drv(1, 2'd1, 0, 16'h0, 16'h0);
    chk("lit_rst_pc", 32'(pc_out), 32'h10);
    chk("lit_rst_ins", 32'(ins_out), 32'h0);
    chk("lit_rst_valid", 32'(ir_valid_out), 32'h0);
    chk("lit_rst_wrap", 32'(pc_wrap_out), 32'h0);

    // load then increment x3
    drv(0, 2'd0, 1, 16'hABCD, 16'h0);
    chk("lit_load_ins", 32'(ins_out), 32'hABCD);
    chk("lit_load_valid", 32'(ir_valid_out), 32'h1);
    chk("lit_load_pc", 32'(pc_out), 32'h10);
    for (int i = 0; i < 3; i++) drv(0, 2'd1, 0, 16'h0, 16'h0);
    chk("lit_inc3_pc", 32'(pc_out), 32'h13);

    // branch -2 from 0x05
    drv(0, 2'd3, 1, 16'h01C6, 16'h0005);
    drv(0, 2'd2, 0, 16'h0, 16'h0);
    chk("lit_br_neg_pc", 32'(pc_out), 32'h03);
    chk("lit_br_neg_wrap", 32'(pc_wrap_out), 32'h0);

    // branch +31 from 0xF0 wraps to 0x0F, pulse one cycle
    drv(0, 2'd3, 1, 16'h00C7, 16'h00F0);
    drv(0, 2'd2, 0, 16'h0, 16'h0);
    chk("lit_br_wrap_pc", 32'(pc_out), 32'h0F);
    chk("lit_br_wrap_pulse", 32'(pc_wrap_out), 32'h1);
    drv(0, 2'd0, 0, 16'h0, 16'h0);
    chk("lit_br_wrap_clear", 32'(pc_wrap_out), 32'h0);

    // jump ignores upper A bits, no wrap
    drv(0, 2'd3, 0, 16'h0, 16'h12C4);
    chk("lit_jmp_pc", 32'(pc_out), 32'hC4);
    chk("lit_jmp_wrap", 32'(pc_wrap_out), 32'h0);

    // increment from 0xFF
    drv(0, 2'd3, 0, 16'h0, 16'h00FF);
    drv(0, 2'd1, 0, 16'h0, 16'h0);
    chk("lit_inc_wrap_pc", 32'(pc_out), 32'h00);
    chk("lit_inc_wrap_pulse", 32'(pc_wrap_out), 32'h1);
    drv(0, 2'd0, 0, 16'h0, 16'h0);

    // branch -2 from 0x01 wraps downward
    drv(0, 2'd3, 1, 16'h01C6, 16'h0001);
    drv(0, 2'd2, 0, 16'h0, 16'h0);
    chk("lit_br_under_pc", 32'(pc_out), 32'hFF);
    chk("lit_br_under_wrap", 32'(pc_wrap_out), 32'h1);

    // same-edge load and branch: old IR offset (+1) used
    drv(0, 2'd3, 1, 16'h0001, 16'h0020);
    drv(0, 2'd2, 1, 16'h0007, 16'h0);
    chk("lit_same_edge_pc", 32'(pc_out), 32'h21);
    chk("lit_same_edge_ins", 32'(ins_out), 32'h0007);
    drv(0, 2'd2, 0, 16'h0, 16'h0);
    chk("lit_new_off_pc", 32'(pc_out), 32'h28);

    // reset during a branch with a load pending
    drv(1, 2'd2, 1, 16'hFFFF, 16'h0);
    chk("lit_rst_mid_pc", 32'(pc_out), 32'h10);
    chk("lit_rst_mid_valid", 32'(ir_valid_out), 32'h0);

    // counters: 4 loads, 2 branches, 1 jump
    for (int i = 0; i < 4; i++) drv(0, 2'd0, 1, 16'h0003, 16'h0);
    drv(0, 2'd2, 0, 16'h0, 16'h0);
    drv(0, 2'd2, 0, 16'h0, 16'h0);
    chk("lit_br_pos_pc", 32'(pc_out), 32'h16);
    drv(0, 2'd3, 0, 16'h0, 16'h0040);
`ifdef PC_IR_STATS_EN
    chk("lit_icnt", instr_cnt_out, 32'd4);
    chk("lit_tcnt", taken_cnt_out, 32'd3);
`else
    chk("lit_icnt_off", instr_cnt_out, 32'd0);
    chk("lit_tcnt_off", taken_cnt_out, 32'd0);
`endif
    drv(1, 2'd0, 0, 16'h0, 16'h0);
    chk("lit_icnt_rst", instr_cnt_out, 32'd0);
    chk("lit_tcnt_rst", taken_cnt_out, 32'd0);
    drv(0, 2'd1, 0, 16'h0, 16'h0);

    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
